// File: rtl/round_off_arbiter_pkg.sv
// Shared types and widths for the posit round_off sharing arbiter.
// Holds the FSM state encoding and the operand/result bundles passed through it.
package round_off_arbiter_pkg;

  localparam int MANT_IN_W  = 64;
  localparam int MANT_OUT_W = 32;
  localparam int K_W        = 6;
  localparam int EXP_W      = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [MANT_IN_W-1:0] mant;
    logic [K_W-1:0]       k;
    logic [EXP_W-1:0]     exp;
    logic                 sign;
  } ro_job_t;

  typedef struct packed {
    logic [MANT_OUT_W-1:0] mant;
    logic [K_W-1:0]        k;
    logic [EXP_W-1:0]      exp;
    logic                  sign;
  } ro_res_t;

endpackage

// File: rtl/round_off_arbiter_rr_arb2.sv
// Two-requester round-robin grant. The pointer names the requester that wins a tie
// and flips to the other requester after every grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
    end
    // Grant to 0 hands priority to 1 and vice versa.
    if (gnt_o != 2'b00) begin
      ptr_d = gnt_o[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/round_off_arbiter.sv
// Shares one round_off unit between the multiplier (0) and adder (1) back-ends:
// grant, issue a start pulse, wait for the done edge (or watchdog), return the result.
module round_off_arbiter
  import round_off_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [MANT_IN_W-1:0]  req0_mant,
  input  logic [K_W-1:0]        req0_k,
  input  logic [EXP_W-1:0]      req0_exp,
  input  logic                  req0_sign,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [MANT_IN_W-1:0]  req1_mant,
  input  logic [K_W-1:0]        req1_k,
  input  logic [EXP_W-1:0]      req1_exp,
  input  logic                  req1_sign,
  output logic                  ro_start,
  output logic [MANT_IN_W-1:0]  ro_shifted_mantissa,
  output logic [K_W-1:0]        ro_k_out,
  output logic [EXP_W-1:0]      ro_exp_out,
  output logic                  ro_sign_out,
  input  logic                  ro_done,
  input  logic [MANT_OUT_W-1:0] ro_mantissa_out,
  input  logic [K_W-1:0]        ro_k_final,
  input  logic [EXP_W-1:0]      ro_exp_final,
  input  logic                  ro_sign_final,
  output logic [1:0]            resp_valid,
  output logic [MANT_OUT_W-1:0] resp_mant,
  output logic [K_W-1:0]        resp_k,
  output logic [EXP_W-1:0]      resp_exp,
  output logic                  resp_sign,
  output logic                  resp_err,
  output logic                  busy,
  output arb_state_e            dbg_state
);

  // Request handshake: a job transfers on the rising edge where reqN_valid and
  // reqN_ready are both high; ready is only ever raised in IDLE, for one winner.

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e       state_q, state_d;
  logic             owner_q, owner_d;
  ro_job_t          job_q, job_d;
  ro_res_t          res_q, res_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic             done_q;

  logic [1:0] gnt;
  logic       done_edge;
  ro_job_t    job0, job1;
  ro_res_t    ro_res;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i ({req1_valid, req0_valid}),
    .en_i  (state_q == IDLE),
    .gnt_o (gnt)
  );

  assign job0   = '{mant: req0_mant, k: req0_k, exp: req0_exp, sign: req0_sign};
  assign job1   = '{mant: req1_mant, k: req1_k, exp: req1_exp, sign: req1_sign};
  assign ro_res = '{mant: ro_mantissa_out, k: ro_k_final, exp: ro_exp_final,
                    sign: ro_sign_final};

  // round_off may still hold done from the previous job, so only a fresh edge counts.
  assign done_edge = ro_done & ~done_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    job_d   = job_q;
    res_d   = res_q;
    err_d   = err_q;
    wd_d    = wd_q;
    case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          owner_d = gnt[1];
          job_d   = gnt[1] ? job1 : job0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A done edge on the watchdog's last cycle still counts as completion.
        if (done_edge) begin
          res_d   = ro_res;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (wd_q == WD_LAST) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      job_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      wd_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      job_q   <= job_d;
      res_q   <= res_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
      done_q  <= ro_done;
    end
  end

  assign req0_ready          = gnt[0];
  assign req1_ready          = gnt[1];
  assign ro_start            = (state_q == ISSUE);
  assign ro_shifted_mantissa = job_q.mant;
  assign ro_k_out            = job_q.k;
  assign ro_exp_out          = job_q.exp;
  assign ro_sign_out         = job_q.sign;
  assign resp_valid          = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign resp_mant           = res_q.mant;
  assign resp_k              = res_q.k;
  assign resp_exp            = res_q.exp;
  assign resp_sign           = res_q.sign;
  assign resp_err            = err_q;
  assign busy                = (state_q != IDLE);
  assign dbg_state           = state_q;

endmodule

// File: tb/tb_round_off_arbiter.sv
// Bench for round_off_arbiter with a behavioural round_off responder; expected
// responses are queued at issue and checked by a negedge monitor.
module tb_round_off_arbiter;
  import round_off_arbiter_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_sign;
  logic [63:0] req0_mant;
  logic [5:0]  req0_k;
  logic [2:0]  req0_exp;
  logic        req1_valid, req1_ready, req1_sign;
  logic [63:0] req1_mant;
  logic [5:0]  req1_k;
  logic [2:0]  req1_exp;
  logic        ro_start, ro_sign_out, ro_done, ro_sign_final;
  logic [63:0] ro_shifted_mantissa;
  logic [5:0]  ro_k_out, ro_k_final;
  logic [2:0]  ro_exp_out, ro_exp_final;
  logic [31:0] ro_mantissa_out;
  logic [1:0]  resp_valid;
  logic [31:0] resp_mant;
  logic [5:0]  resp_k;
  logic [2:0]  resp_exp;
  logic        resp_sign, resp_err, busy;
  arb_state_e  dbg_state;

  round_off_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mant(req0_mant),
    .req0_k(req0_k), .req0_exp(req0_exp), .req0_sign(req0_sign),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mant(req1_mant),
    .req1_k(req1_k), .req1_exp(req1_exp), .req1_sign(req1_sign),
    .ro_start(ro_start), .ro_shifted_mantissa(ro_shifted_mantissa),
    .ro_k_out(ro_k_out), .ro_exp_out(ro_exp_out), .ro_sign_out(ro_sign_out),
    .ro_done(ro_done), .ro_mantissa_out(ro_mantissa_out), .ro_k_final(ro_k_final),
    .ro_exp_final(ro_exp_final), .ro_sign_final(ro_sign_final),
    .resp_valid(resp_valid), .resp_mant(resp_mant), .resp_k(resp_k),
    .resp_exp(resp_exp), .resp_sign(resp_sign), .resp_err(resp_err),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [1:0]  v;
    logic [31:0] mant;
    logic [5:0]  k;
    logic [2:0]  e;
    logic        s;
    logic        err;
    logic [7:0]  lat;
    logic [7:0]  waits;
  } exp_t;
  typedef struct packed {
    logic [63:0] m;
    logic [5:0]  k;
    logic [2:0]  e;
    logic        s;
  } op_t;
  localparam int RW = $bits(exp_t);
  localparam int OW = $bits(op_t);
  logic [RW-1:0] exp_q[$];
  logic [OW-1:0] op_q[$];

  int tests = 0;
  int fails = 0;
  int grant_cyc = 0;
  int wait_cnt = 0;
  logic prev_start = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void push_op(logic [63:0] m, logic [5:0] k, logic [2:0] e, logic s);
    op_t o;
    o.m = m; o.k = k; o.e = e; o.s = s;
    op_q.push_back(o);
  endfunction

  // Expected response as given explicitly by the caller.
  function automatic void push_rsp(logic [1:0] v, logic [31:0] m, logic [5:0] k,
                                   logic [2:0] e, logic s, logic err, int lat, int waits);
    exp_t x;
    x.v = v; x.mant = m; x.k = k; x.e = e; x.s = s; x.err = err;
    x.lat = 8'(lat); x.waits = 8'(waits);
    exp_q.push_back(x);
  endfunction

  // Round_off stand-in transform: mant = hi^lo^DEADBEEF, k+1, exp^5, sign kept.
  function automatic void push_job(logic [1:0] v, logic [63:0] m, logic [5:0] k,
                                   logic [2:0] e, logic s, int lat, int waits);
    push_op(m, k, e, s);
    push_rsp(v, m[63:32] ^ m[31:0] ^ 32'hDEAD_BEEF, k + 6'd1, e ^ 3'b101, s, 1'b0,
             lat, waits);
  endfunction

  // ---------------- round_off model ----------------
  logic [7:0]  m_lat, m_stale;
  logic        m_hold;
  logic [7:0]  cnt_q, stale_q;
  logic [31:0] pend_mant;
  logic [5:0]  pend_k;
  logic [2:0]  pend_e;
  logic        pend_s;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 0; stale_q <= 0; ro_done <= 0;
      ro_mantissa_out <= 0; ro_k_final <= 0; ro_exp_final <= 0; ro_sign_final <= 0;
      pend_mant <= 0; pend_k <= 0; pend_e <= 0; pend_s <= 0;
    end else if (ro_start) begin
      cnt_q     <= m_lat;
      stale_q   <= m_stale;
      pend_mant <= ro_shifted_mantissa[63:32] ^ ro_shifted_mantissa[31:0] ^ 32'hDEAD_BEEF;
      pend_k    <= ro_k_out + 6'd1;
      pend_e    <= ro_exp_out ^ 3'b101;
      pend_s    <= ro_sign_out;
    end else if (stale_q != 0) begin
      stale_q <= stale_q - 1;
      if (stale_q == 1) ro_done <= 1'b0;
    end else if (cnt_q != 0) begin
      cnt_q <= cnt_q - 1;
      if (cnt_q == 1) begin
        ro_done <= 1'b1;
        ro_mantissa_out <= pend_mant; ro_k_final <= pend_k;
        ro_exp_final <= pend_e; ro_sign_final <= pend_s;
      end
    end else if (!m_hold) begin
      ro_done <= 1'b0;
    end
  end

  // ---------------- monitor ----------------
  exp_t mx;
  op_t  mo;
  always @(negedge clk) begin
    if (rst_n) begin
      if (dbg_state == ISSUE) wait_cnt = 0;
      else if (dbg_state == WAIT) wait_cnt++;
      if (busy) chk("ready_while_busy", {62'd0, req1_ready, req0_ready}, 64'd0);
      if (ro_start) begin
        chk("start_width", {63'd0, prev_start}, 64'd0);
        if (op_q.size() == 0) begin
          chk("unexpected_start", 64'd1, 64'd0);
        end else begin
          mo = op_t'(op_q.pop_front());
          chk("ro_mant", ro_shifted_mantissa, mo.m);
          chk("ro_kexps", {55'd0, ro_k_out, ro_exp_out, ro_sign_out},
              {55'd0, mo.k, mo.e, mo.s});
        end
      end
      prev_start = ro_start;
      if (resp_valid != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", {62'd0, resp_valid}, 64'd0);
        end else begin
          mx = exp_t'(exp_q.pop_front());
          chk("resp_valid", {62'd0, resp_valid}, {62'd0, mx.v});
          chk("resp_mant", {32'd0, resp_mant}, {32'd0, mx.mant});
          chk("resp_kes", {54'd0, resp_k, resp_exp, resp_sign},
              {54'd0, mx.k, mx.e, mx.s});
          chk("resp_err", {63'd0, resp_err}, {63'd0, mx.err});
          if (mx.lat != 0) chk("latency", 64'(cyc - grant_cyc + 1), 64'(mx.lat));
          if (mx.waits != 0) chk("wait_cycles", 64'(wait_cnt), 64'(mx.waits));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int idx, input logic [63:0] m, input logic [5:0] k,
                       input logic [2:0] e, input logic s);
    int n = 0;
    if (idx == 0) begin
      req0_valid = 1; req0_mant = m; req0_k = k; req0_exp = e; req0_sign = s;
    end else begin
      req1_valid = 1; req1_mant = m; req1_k = k; req1_exp = e; req1_sign = s;
    end
    #1;
    while (!((idx == 0) ? req0_ready : req1_ready) && n < 300) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 300) chk("grant_timeout", 64'(idx), 64'hFFFF);
    else grant_cyc = cyc;
    @(negedge clk);
    if (idx == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk); n++;
    end
    if (n >= budget) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ro"}, {ro_shifted_mantissa ^ 64'(ro_k_out) ^ 64'(ro_exp_out)},
        64'd0);
    chk({tag, "_ctl"}, {57'd0, ro_start, ro_sign_out, resp_valid, resp_err,
        req0_ready | req1_ready, busy}, 64'd0);
    chk({tag, "_resp"}, {22'd0, resp_mant, resp_k, resp_exp, resp_sign}, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1;
    req0_valid = 0; req0_mant = 0; req0_k = 0; req0_exp = 0; req0_sign = 0;
    req1_valid = 0; req1_mant = 0; req1_k = 0; req1_exp = 0; req1_sign = 0;
    m_lat = 2; m_stale = 0; m_hold = 0;
    #1 rst_n = 0;
    repeat (2) @(negedge clk);
    #1 check_all_zero("reset");
    rst_n = 1;
    @(negedge clk);
    check_all_zero("post_reset");

    // Contention: four back-to-back jobs, grants alternate 0,1,0,1.
    m_lat = 2;
    push_job(2'b01, 64'h0123_4567_89AB_CDEF, 6'd1, 3'd2, 1'b0, 6, 3);
    push_job(2'b10, 64'h1111_2222_3333_4444, 6'd3, 3'd7, 1'b1, 6, 3);
    push_job(2'b01, 64'h0000_0000_FFFF_0000, 6'h3E, 3'd0, 1'b1, 6, 3);
    push_job(2'b10, 64'h8000_0000_0000_0001, 6'd0, 3'd5, 1'b0, 6, 3);
    fork
      begin
        drive(0, 64'h0123_4567_89AB_CDEF, 6'd1, 3'd2, 1'b0);
        drive(0, 64'h0000_0000_FFFF_0000, 6'h3E, 3'd0, 1'b1);
      end
      begin
        drive(1, 64'h1111_2222_3333_4444, 6'd3, 3'd7, 1'b1);
        drive(1, 64'h8000_0000_0000_0001, 6'd0, 3'd5, 1'b0);
      end
    join
    drain(100);

    // Single job, hand-computed result DEAD_BEEF, k 3, exp 4, latency 7.
    m_lat = 3;
    push_op(64'hFFFF_FFFF_FFFF_FFFF, 6'd2, 3'd1, 1'b0);
    push_rsp(2'b01, 32'hDEAD_BEEF, 6'd3, 3'd4, 1'b0, 1'b0, 7, 4);
    drive(0, 64'hFFFF_FFFF_FFFF_FFFF, 6'd2, 3'd1, 1'b0);
    drain(50);

    // Stale done: done stays high after job A; job B must wait for a fresh edge.
    m_hold = 1; m_lat = 2; m_stale = 0;
    push_job(2'b01, 64'hAAAA_0000_5555_0000, 6'd4, 3'd3, 1'b0, 6, 3);
    drive(0, 64'hAAAA_0000_5555_0000, 6'd4, 3'd3, 1'b0);
    drain(50);
    repeat (2) @(negedge clk);
    m_lat = 3; m_stale = 2;
    push_job(2'b10, 64'h1234_5678_0000_FFFF, 6'd9, 3'd6, 1'b1, 9, 6);
    drive(1, 64'h1234_5678_0000_FFFF, 6'd9, 3'd6, 1'b1);
    drain(50);
    m_hold = 0; m_stale = 0;
    repeat (2) @(negedge clk);

    // Timeout: done never rises; then a normal job.
    m_lat = 0;
    push_op(64'h0F0F_0F0F_0F0F_0F0F, 6'd5, 3'd2, 1'b1);
    push_rsp(2'b10, 32'd0, 6'd0, 3'd0, 1'b0, 1'b1, 11, TO);
    drive(1, 64'h0F0F_0F0F_0F0F_0F0F, 6'd5, 3'd2, 1'b1);
    drain(60);
    m_lat = 2;
    push_job(2'b01, 64'hCAFE_F00D_0000_0001, 6'd7, 3'd1, 1'b0, 6, 3);
    drive(0, 64'hCAFE_F00D_0000_0001, 6'd7, 3'd1, 1'b0);
    drain(50);

    // Done rises on the final watchdog cycle: completion wins.
    m_lat = 7;
    push_job(2'b01, 64'h0000_0001_0000_0002, 6'd10, 3'd3, 1'b1, 11, 8);
    drive(0, 64'h0000_0001_0000_0002, 6'd10, 3'd3, 1'b1);
    drain(60);

    // Reset while in WAIT: job discarded, outputs clear at once.
    m_lat = 20;
    push_op(64'h5A5A_5A5A_A5A5_A5A5, 6'd12, 3'd4, 1'b0);
    drive(1, 64'h5A5A_5A5A_A5A5_A5A5, 6'd12, 3'd4, 1'b0);
    repeat (3) @(negedge clk);
    chk("in_wait_before_reset", 64'(dbg_state), 64'(WAIT));
    rst_n = 0;
    #1 check_all_zero("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1;
    m_lat = 3;
    push_job(2'b10, 64'h0000_0000_0000_0000, 6'h39, 3'd0, 1'b1, 7, 4);
    drive(1, 64'h0000_0000_0000_0000, 6'h39, 3'd0, 1'b1);
    drain(50);
    repeat (3) @(negedge clk);
    chk("leftover_ops", 64'(op_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/round_off_arbiter.md
Name: round_off_arbiter

Overview:
- Shares one round_off rounding unit between two posit datapath requesters: requester 0 is the multiplier back-end, requester 1 is the adder back-end.
- Accepts jobs with a valid/ready handshake, arbitrates round-robin and issues the 1-cycle start pulse to round_off.
- Waits for round_off's done, captures the rounded result and returns it to the owning requester.
- A watchdog aborts a job that never completes.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles in WAIT before abort (legal range 2..2**CNT_W-1).
- CNT_W, 7: watchdog counter width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has a job.
- req0_ready  out  1  requester 0 job accepted this cycle.
- req0_mant  in  64  requester 0 shifted mantissa.
- req0_k  in  6  requester 0 regime k, two's complement.
- req0_exp  in  3  requester 0 exponent.
- req0_sign  in  1  requester 0 sign.
- req1_valid, req1_ready, req1_mant, req1_k, req1_exp, req1_sign: same widths and meaning for requester 1.
- ro_start  out  1  start pulse to round_off.
- ro_shifted_mantissa  out  64  operand to round_off.
- ro_k_out  out  6  operand to round_off.
- ro_exp_out  out  3  operand to round_off.
- ro_sign_out  out  1  operand to round_off.
- ro_done  in  1  round_off done (level or pulse).
- ro_mantissa_out  in  32  round_off result.
- ro_k_final  in  6  round_off result.
- ro_exp_final  in  3  round_off result.
- ro_sign_final  in  1  round_off result.
- resp_valid  out  2  one-hot 1-cycle pulse; bit i = result for requester i.
- resp_mant  out  32  captured result, shared by both requesters.
- resp_k  out  6  captured result.
- resp_exp  out  3  captured result.
- resp_sign  out  1  captured result.
- resp_err  out  1  with resp_valid: 1 = job aborted by timeout, result fields zero.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - FSM to IDLE.
  - All outputs 0, including ro_* operands, resp_* and both readies.
  - Round-robin priority pointer to 0; done_q to 0; watchdog to 0.
- States are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Only one valid: that requester wins.
  - Both valid: the requester named by the priority pointer wins.
  - The winner's reqN_ready is asserted combinationally in the same cycle. The handshake completes on that edge: operands are latched into the ro_* registers, owner is recorded, and the FSM goes to ISSUE.
  - Priority pointer is set to the other requester after every grant.
  - Readies are 0 in every other state.
- ISSUE:
  - ro_start=1 for exactly this one cycle; ro_* operands held stable from ISSUE until leaving WAIT.
  - Watchdog cleared; next state WAIT.
- WAIT:
  - done_q is a register of ro_done updated every cycle.
  - Completion is the rising edge, ro_done & ~done_q. This covers round_off holding done high from the previous job.
  - On completion: latch ro_mantissa_out, ro_k_final, ro_exp_final, ro_sign_final into resp_*; resp_err=0; go to RESP.
  - Otherwise the watchdog increments. When it reaches TIMEOUT_CYCLES-1 with no edge: resp_* fields=0, resp_err=1, go to RESP.
- RESP:
  - resp_valid[owner]=1 for one cycle; then IDLE.
  - resp_* fields hold until the next capture.
- Latency, grant edge to resp_valid: ISSUE 1 + WAIT (N+1) + RESP, where N = round_off cycles from start to done.
- Throughput: at most one job in flight. The earliest next grant is the cycle after RESP.
- Simultaneous events:
  - A requester that drops valid before ready is simply not granted; no error.
  - ro_done rising in the same cycle the watchdog expires: completion wins and resp_err=0.
- Reset mid-operation: the job is discarded, no resp_valid is emitted and the FSM returns to IDLE. round_off is reset by the same rst_n.
- k is carried as 6-bit two's complement; no width conversion.

Decomposition:
- Shared posit package holds:
  - state enum localparams IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3;
  - width constants MANT_IN_W=64, MANT_OUT_W=32, K_W=6, EXP_W=3.
- One natural sub-module: rr_arb2, a 2-requester round-robin grant with priority pointer.
- round_off is instantiated at the parent level, not inside this block.

Test Plan:
- Single job: req0 {mant=64'hFFFF_FFFF_FFFF_FFFF, k=2, exp=3'd1, sign=0}, round_off model returns done after 3 cycles with mantissa 32'hDEAD_BEEF -> ro_start exactly 1 cycle, resp_valid=2'b01, resp_mant=32'hDEAD_BEEF, resp_err=0, latency 7 cycles from grant.
- Contention: both requesters valid for 4 back-to-back jobs from reset -> grant order 0,1,0,1; resp_valid alternates 01,10,01,10; no ready while busy.
- Stale done: round_off model holds done high between jobs; second job issued -> no capture until done falls and rises again, and the result matches job 2 operands.
- Timeout: TIMEOUT_CYCLES=8, model never raises done -> resp_valid=2'b10 with resp_err=1, resp_mant=0, exactly 8 WAIT cycles; the next job then completes normally.
- Done/timeout tie: done rises on the final WAIT cycle -> resp_err=0 with the captured result.
- Reset in WAIT: assert rst_n=0 for 2 cycles mid-job -> all outputs 0 immediately, no resp_valid; after release a req1 job with k=-6'sd7 completes correctly.
